// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the cache miss/fill path.
package cache_pkg;

    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_BYTES        = 2;
    localparam int unsigned WORDS_PER_BLOCK   = 8;

    localparam int unsigned STATE_WIDTH = 1;
    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t FILL = 1'b1;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating up-counter with synchronous clear; tracks words requested or returned in a fill.
module fill_counter #(
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned MAX_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_max_c
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(MAX_COUNT);

    assign at_max_c = (count == MAX_VAL);

    // Clear wins over enable so a new fill always starts from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max_c) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches an 8-word block from main memory, streams each returned word
// into the data array and writes the tag alongside the last word.
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned CNT_WIDTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_req_address,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array
);

    import cache_pkg::*;

    localparam int unsigned WORD_IDX_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BYTE_BITS     = $clog2(WORD_BYTES);
    localparam int unsigned BASE_BITS     = ADDR_WIDTH - BLOCK_OFFSET_BITS;

    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(WORDS_PER_BLOCK - 1);

    state_t                 state;
    state_t                 next_state;
    logic [BASE_BITS-1:0]   base_hi;
    logic [BASE_BITS-1:0]   next_base_hi;
    logic [CNT_WIDTH-1:0]   req_cnt;
    logic [CNT_WIDTH-1:0]   ret_cnt;
    logic                   req_done_c;
    logic                   ret_done_c;
    logic                   cnt_clear;
    logic                   req_step;
    logic                   ret_step;

    // Only the block-aligned part of the miss address is kept.
    logic unused_offset;
    assign unused_offset = ^miss_address[BLOCK_OFFSET_BITS-1:0];

    fill_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_COUNT (WORDS_PER_BLOCK)
    ) u_req_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (req_step),
        .count    (req_cnt),
        .at_max_c (req_done_c)
    );

    fill_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_COUNT (WORDS_PER_BLOCK)
    ) u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (ret_step),
        .count    (ret_cnt),
        .at_max_c (ret_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_hi <= '0;
        end else begin
            state   <= next_state;
            base_hi <= next_base_hi;
        end
    end

    // Word addresses only vary in the in-block offset, so a fill never leaves its block.
    always_comb begin
        next_state       = state;
        next_base_hi     = base_hi;
        cnt_clear        = 1'b0;
        req_step         = 1'b0;
        ret_step         = 1'b0;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        mem_req_address  = '0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    next_base_hi = miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
                    cnt_clear    = 1'b1;
                    next_state   = FILL;
                end
            end

            FILL: begin
                fsm_busy       = 1'b1;
                memory_address = {base_hi, ret_cnt[WORD_IDX_BITS-1:0], BYTE_BITS'(0)};
                if (!req_done_c) begin
                    mem_enable      = 1'b1;
                    req_step        = 1'b1;
                    mem_req_address = {base_hi, req_cnt[WORD_IDX_BITS-1:0], BYTE_BITS'(0)};
                end
                if (memory_data_valid && !ret_done_c) begin
                    write_data_array = 1'b1;
                    ret_step         = 1'b1;
                    if (ret_cnt == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        next_state      = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: inputs driven and outputs sampled just after each falling edge.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] mem_req_address;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;

    int tests   = 0;
    int fails   = 0;
    int wr_cnt  = 0;
    int tag_cnt = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .mem_req_address   (mem_req_address),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tg);
        check({tg, " busy"}, 16'(fsm_busy), 16'h0);
        check({tg, " en"},   16'(mem_enable), 16'h0);
        check({tg, " req"},  mem_req_address, 16'h0);
        check({tg, " maddr"}, memory_address, 16'h0);
        check({tg, " wd"},   16'(write_data_array), 16'h0);
        check({tg, " wt"},   16'(write_tag_array), 16'h0);
    endtask

    // One cycle: apply inputs, then compare every output against the hand-derived values.
    task automatic cyc(input string tg, input logic m, input logic [15:0] a, input logic v,
                       input logic e_busy, input logic e_en, input logic [15:0] e_req,
                       input logic [15:0] e_maddr, input logic e_wd, input logic e_wt);
        @(negedge clk);
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        #1;
        check({tg, " busy"}, 16'(fsm_busy), 16'(e_busy));
        check({tg, " en"},   16'(mem_enable), 16'(e_en));
        if (e_en || !e_busy) check({tg, " req"}, mem_req_address, e_req);
        check({tg, " maddr"}, memory_address, e_maddr);
        check({tg, " wd"},   16'(write_data_array), 16'(e_wd));
        check({tg, " wt"},   16'(write_tag_array), 16'(e_wt));
        if (write_data_array) wr_cnt++;
        if (write_tag_array)  tag_cnt++;
    endtask

    // Fill with 4-cycle memory: detect C0, requests C1..C8, returns C5..C12, idle at C13.
    task automatic run_lat4(input logic [15:0] maddr, input bit perturb, input int last_c,
                            input string tg);
        logic [15:0] base;
        base = maddr & 16'hFFF0;
        for (int c = 0; c <= last_c; c++) begin
            logic        m, v, eb, ee, ewd, ewt;
            logic [15:0] a, er, ema;
            int          nret;
            m = (c <= 12);
            a = maddr;
            if (perturb && c == 2) m = 1'b0;
            if (perturb && c >= 3) a = 16'hABCD;
            v    = (c >= 5 && c <= 12);
            eb   = (c >= 1 && c <= 12);
            ee   = (c >= 1 && c <= 8);
            er   = ee ? base + 16'(2 * (c - 1)) : 16'h0;
            nret = (c >= 5) ? c - 5 : 0;
            ema  = eb ? base + 16'(2 * nret) : 16'h0;
            ewd  = v && eb;
            ewt  = (c == 12);
            cyc($sformatf("%s c%0d", tg, c), m, a, v, eb, ee, er, ema, ewd, ewt);
        end
    endtask

    // Reset asserted mid-cycle must clear outputs at once and hold the FSM idle.
    task automatic async_reset(input string tg);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle({tg, " async"});
        @(negedge clk);
        miss_detected     = 1'b1;
        memory_data_valid = 1'b1;
        #1;
        check_idle({tg, " held"});
        @(negedge clk);
        rst               = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        #1;
        check_idle({tg, " release"});
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        #1;
        check_idle("t1 por");
        @(negedge clk);
        rst = 1'b0;

        run_lat4(16'h5556, 1'b0, 2, "t1");
        async_reset("t1 rst");

        wr_cnt = 0; tag_cnt = 0;
        run_lat4(16'h1236, 1'b0, 13, "t2");
        check("t2 writes", 16'(wr_cnt), 16'd8);
        check("t2 tags", 16'(tag_cnt), 16'd1);

        // Returns on alternate cycles C2,C4..C16; the 8th lands at C16.
        wr_cnt = 0; tag_cnt = 0;
        for (int c = 0; c <= 17; c++) begin
            logic        m, v, eb, ee, ewd, ewt;
            logic [15:0] er, ema;
            int          nret;
            m    = (c <= 16);
            v    = (c >= 2 && c <= 16 && (c % 2) == 0);
            eb   = (c >= 1 && c <= 16);
            ee   = (c >= 1 && c <= 8);
            er   = ee ? 16'h2460 + 16'(2 * (c - 1)) : 16'h0;
            nret = (c >= 1) ? (c - 1) / 2 : 0;
            ema  = eb ? 16'h2460 + 16'(2 * nret) : 16'h0;
            ewd  = v && eb;
            ewt  = (c == 16);
            cyc($sformatf("t3 c%0d", c), m, 16'h2468, v, eb, ee, er, ema, ewd, ewt);
        end
        check("t3 writes", 16'(wr_cnt), 16'd8);
        check("t3 tags", 16'(tag_cnt), 16'd1);

        wr_cnt = 0; tag_cnt = 0;
        run_lat4(16'h4440, 1'b1, 13, "t4");
        cyc("t4 spur0", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cyc("t4 spur1", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("t4 writes", 16'(wr_cnt), 16'd8);
        check("t4 tags", 16'(tag_cnt), 16'd1);

        wr_cnt = 0; tag_cnt = 0;
        run_lat4(16'h7778, 1'b0, 7, "t5a");
        check("t5a writes", 16'(wr_cnt), 16'd3);
        async_reset("t5 rst");
        wr_cnt = 0; tag_cnt = 0;
        run_lat4(16'hFFF2, 1'b0, 13, "t5b");
        check("t5b writes", 16'(wr_cnt), 16'd8);
        check("t5b tags", 16'(tag_cnt), 16'd1);

        // Miss for 0x0040 presented in the first IDLE cycle after the 0x0010 fill.
        wr_cnt = 0; tag_cnt = 0;
        run_lat4(16'h0010, 1'b0, 12, "t6a");
        run_lat4(16'h0040, 1'b0, 13, "t6b");
        check("t6 writes", 16'(wr_cnt), 16'd16);
        check("t6 tags", 16'(tag_cnt), 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
